debounce_fsm: RTL and testbench

- Debounce controller that sits directly downstream of the Timer block (clk, reset, enable, done).
- Consumes the Timer's `done` tick and drives the Timer's `enable` and `reset` inputs.
- Synchronises a raw push-button input and qualifies each level change only after it has held for STABLE_TICKS consecutive Timer ticks.
- Outputs a clean level, one-cycle press/release strobes and a press counter for the debug display logic.

---
 rtl/debounce_fsm.sv | 141 ++++++++++++++
 tb/tb_debounce_fsm.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/debounce_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// debounce_fsm : push-button debouncer that qualifies level changes with
//                Timer ticks and reports press/release strobes and a count.
// Revision 1.0
// ----------------------------------------------------------------------------
module debounce_fsm #(
    parameter int STABLE_TICKS = 2,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_in,
    input  logic             tick,
    output logic             timer_en,
    output logic             timer_clr,
    output logic             btn_level,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic [CNT_W-1:0] press_count
);

    typedef enum logic [1:0] {
        REL_STABLE   = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESS_STABLE = 2'd2,
        REL_WAIT     = 2'd3
    } state_t;

    localparam logic [3:0]       LAST_TICK = 4'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             s1_q, btn_s_q, tick_q;
    logic [3:0]       stable_cnt_q, stable_cnt_d;
    logic             timer_en_q, timer_en_d;
    logic             timer_clr_q, timer_clr_d;
    logic             btn_level_q, btn_level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_rise;

    // The tick edge is masked while the Timer is being cleared.
    assign tick_rise = tick & ~tick_q & ~timer_clr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= REL_STABLE;
            s1_q         <= 1'b0;
            btn_s_q      <= 1'b0;
            tick_q       <= 1'b0;
            stable_cnt_q <= 4'd0;
            timer_en_q   <= 1'b0;
            timer_clr_q  <= 1'b0;
            btn_level_q  <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            s1_q         <= btn_in;
            btn_s_q      <= s1_q;
            tick_q       <= tick;
            stable_cnt_q <= stable_cnt_d;
            timer_en_q   <= timer_en_d;
            timer_clr_q  <= timer_clr_d;
            btn_level_q  <= btn_level_d;
            press_q      <= press_d;
            release_q    <= release_d;
            count_q      <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        stable_cnt_d = stable_cnt_q;
        timer_clr_d  = 1'b0;
        btn_level_d  = btn_level_q;
        press_d      = 1'b0;
        release_d    = 1'b0;
        count_d      = count_q;
        case (state_q)
            REL_STABLE: begin
                if (btn_s_q) begin
                    state_d      = PRESS_WAIT;
                    stable_cnt_d = 4'd0;
                    timer_clr_d  = 1'b1;
                end
            end
            PRESS_WAIT: begin
                // A bounce takes priority over a coincident completing tick.
                if (!btn_s_q) begin
                    state_d     = REL_STABLE;
                    timer_clr_d = 1'b1;
                end else if (tick_rise) begin
                    if (stable_cnt_q == LAST_TICK) begin
                        state_d     = PRESS_STABLE;
                        btn_level_d = 1'b1;
                        press_d     = 1'b1;
                        count_d     = count_q + CNT_ONE;
                    end else begin
                        stable_cnt_d = stable_cnt_q + 4'd1;
                    end
                end
            end
            PRESS_STABLE: begin
                if (!btn_s_q) begin
                    state_d      = REL_WAIT;
                    stable_cnt_d = 4'd0;
                    timer_clr_d  = 1'b1;
                end
            end
            REL_WAIT: begin
                if (btn_s_q) begin
                    state_d     = PRESS_STABLE;
                    timer_clr_d = 1'b1;
                end else if (tick_rise) begin
                    if (stable_cnt_q == LAST_TICK) begin
                        state_d     = REL_STABLE;
                        btn_level_d = 1'b0;
                        release_d   = 1'b1;
                    end else begin
                        stable_cnt_d = stable_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = REL_STABLE;
        endcase
        timer_en_d = (state_d == PRESS_WAIT) || (state_d == REL_WAIT);
    end

    assign timer_en      = timer_en_q;
    assign timer_clr     = timer_clr_q;
    assign btn_level     = btn_level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign press_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_debounce_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_debounce_fsm : randomized bench for debounce_fsm with a Timer model and
//                   a level/window reference model compared every cycle.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_debounce_fsm;

    localparam int STABLE_TICKS = 2;
    localparam int CNT_W        = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             btn_in;
    logic             tick;
    logic             timer_en, timer_clr, btn_level, press_pulse, release_pulse;
    logic [CNT_W-1:0] press_count;

    logic             force_en, force_val;
    logic             timer_tick_q = 1'b0;
    int               tcnt_q = 0;

    int               checks = 0;
    int               errors = 0;
    logic             chk_on = 1'b0;

    // reference model: accepted level, open qualification window, ticks seen
    logic m_s1 = 0, m_bs = 0, m_tprev = 0;
    logic m_level = 0, m_win = 0, m_clr = 0, m_press = 0, m_rel = 0;
    int   m_ticks = 0, m_count = 0;

    always #5 clk = ~clk;

    assign tick = force_en ? force_val : timer_tick_q;

    debounce_fsm #(.STABLE_TICKS(STABLE_TICKS), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in), .tick(tick),
        .timer_en(timer_en), .timer_clr(timer_clr), .btn_level(btn_level),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .press_count(press_count)
    );

    // Timer: one-cycle done every 10 enabled cycles, restarted by clear
    always @(posedge clk) begin
        if (reset || timer_clr) begin
            tcnt_q       <= 0;
            timer_tick_q <= 1'b0;
        end else if (timer_en) begin
            tcnt_q       <= (tcnt_q == 9) ? 0 : tcnt_q + 1;
            timer_tick_q <= (tcnt_q == 9);
        end else begin
            timer_tick_q <= 1'b0;
        end
    end

    task automatic model_step();
        logic rise, bs_old;
        if (reset) begin
            m_s1 = 0; m_bs = 0; m_tprev = 0; m_level = 0; m_win = 0;
            m_clr = 0; m_press = 0; m_rel = 0; m_ticks = 0; m_count = 0;
        end else begin
            rise    = tick && !m_tprev && !m_clr;
            m_tprev = tick;
            bs_old  = m_bs;
            m_bs    = m_s1;
            m_s1    = btn_in;
            m_clr = 0; m_press = 0; m_rel = 0;
            if (!m_win) begin
                if (bs_old != m_level) begin
                    m_win = 1; m_ticks = 0; m_clr = 1;
                end
            end else if (bs_old == m_level) begin
                m_win = 0; m_clr = 1;
            end else if (rise) begin
                m_ticks++;
                if (m_ticks == STABLE_TICKS) begin
                    m_win   = 0;
                    m_level = !m_level;
                    if (m_level) begin
                        m_press = 1;
                        m_count = (m_count + 1) % (1 << CNT_W);
                    end else begin
                        m_rel = 1;
                    end
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {19'd0, timer_en, timer_clr, btn_level, press_pulse, release_pulse, press_count};
    endfunction

    function automatic logic [31:0] model_vec();
        return {19'd0, m_win, m_clr, m_level, m_press, m_rel, 8'(m_count)};
    endfunction

    always @(negedge clk) if (chk_on) check("cycle", dut_vec(), model_vec());

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tick();
        force_val = 1'b1; cyc(1);
        force_val = 1'b0; cyc(1);
    endtask

    task automatic wait_en();
        for (int i = 0; i < 60; i++) begin
            if (timer_en) break;
            cyc(1);
        end
        check("wait_en", {31'd0, timer_en}, 32'd1);
    endtask

    task automatic fast_toggle(input logic lvl);
        btn_in = lvl; cyc(6);
        pulse_tick(); pulse_tick(); cyc(2);
    endtask

    initial begin
        int snap;
        reset = 1'b1; btn_in = 1'b0; force_en = 1'b0; force_val = 1'b0;
        cyc(3);
        chk_on = 1'b1;
        reset  = 1'b0;

        // idle after reset
        cyc(50);
        check("idle", dut_vec(), 32'd0);

        // clean press and release with the Timer model
        btn_in = 1'b1; cyc(40);
        check("press_lvl", {31'd0, btn_level}, 32'd1);
        check("press_cnt", {24'd0, press_count}, 32'd1);
        btn_in = 1'b0; cyc(40);
        check("rel_lvl", {31'd0, btn_level}, 32'd0);
        check("rel_cnt", {24'd0, press_count}, 32'd1);

        // short bounce
        btn_in = 1'b1; cyc(5);
        btn_in = 1'b0; cyc(30);
        check("bounce_lvl", {31'd0, btn_level}, 32'd0);
        check("bounce_cnt", {24'd0, press_count}, 32'd1);

        // bounce coincident with completing tick
        force_en = 1'b1; snap = m_count;
        btn_in = 1'b1; cyc(6);
        pulse_tick(); cyc(1);
        btn_in = 1'b0; cyc(2);
        force_val = 1'b1; cyc(1);
        force_val = 1'b0; cyc(5);
        check("coinc_lvl", {31'd0, btn_level}, 32'd0);
        check("coinc_cnt", {24'd0, press_count}, 32'(snap));

        // tick stuck high counts once
        btn_in = 1'b1; cyc(6);
        force_val = 1'b1; cyc(30);
        check("stuck_lvl", {31'd0, btn_level}, 32'd0);
        force_val = 1'b0; cyc(1);
        pulse_tick(); cyc(3);
        check("stuck_acc", {31'd0, btn_level}, 32'd1);
        check("stuck_cnt", {24'd0, press_count}, 32'(snap + 1));
        force_en = 1'b0;
        btn_in = 1'b0; cyc(40);

        // wrap the press counter
        force_en = 1'b1;
        snap = (1 << CNT_W) - m_count;
        for (int i = 0; i < snap; i++) begin
            fast_toggle(1'b1);
            fast_toggle(1'b0);
        end
        check("wrap_cnt", {24'd0, press_count}, 32'd0);

        // randomized segments
        for (int i = 0; i < 150; i++) begin
            int hold;
            logic fmode;
            btn_in = 1'($urandom_range(0, 1));
            hold   = $urandom_range(1, 40);
            fmode  = ($urandom_range(0, 3) == 0);
            force_en = fmode;
            for (int k = 0; k < hold; k++) begin
                force_val = ($urandom_range(0, 2) == 0);
                reset     = ($urandom_range(0, 200) == 0);
                cyc(1);
            end
            reset = 1'b0;
        end
        force_en = 1'b0; force_val = 1'b0;

        // reset inside the press window
        btn_in = 1'b0; cyc(40);
        btn_in = 1'b1; cyc(3);
        wait_en();
        reset = 1'b1; cyc(1);
        check("rst_pw", dut_vec(), 32'd0);
        reset = 1'b0; btn_in = 1'b0; cyc(10);

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
